// File: rtl/io_uart_tx_responder_if.sv
// rtl/io_uart_tx_responder_if.sv - CPU I/O bus bundle for the UART TX responder
//
// Signals:
//   io_addr    CPU I/O address, driven continuously (no read strobe)
//   io_write   single-cycle write strobe
//   io_wr_data write data
//   io_rd_data combinational read data, zero when the responder is not selected
//
// Modports: master = CPU side, slave = responder side.
interface io_uart_tx_responder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] io_addr;
  logic             io_write;
  logic [WIDTH-1:0] io_wr_data;
  logic [WIDTH-1:0] io_rd_data;

  modport master (
    output io_addr,
    output io_write,
    output io_wr_data,
    input  io_rd_data
  );

  modport slave (
    input  io_addr,
    input  io_write,
    input  io_wr_data,
    output io_rd_data
  );
endinterface

// File: rtl/io_uart_tx_responder.sv
// rtl/io_uart_tx_responder.sv - memory-mapped 8N1 UART transmitter on the CPU I/O bus
//
// Ports:
//   clock    system clock
//   reset    synchronous, active-high
//   bus      io_uart_tx_responder_if.slave (io_addr, io_write, io_wr_data, io_rd_data)
//   tx       serial line, idle high, registered
//   tx_busy  FIFO non-empty or frame in progress, registered
//
// Registers (index = io_addr[1:0]):
//   0 TXDATA  W: push byte; R: 0
//   1 STATUS  R: {count[7:4], 0, overflow, idle, full}; W: bit2=1 clears overflow
//   2 DIV     R/W clocks per bit; writing 0 stores 1
//   3 reserved
module io_uart_tx_responder #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] BASE      = 'h4000,
  parameter int               DEPTH     = 8,
  parameter int               DIV_RESET = 217
) (
  input  logic                  clock,
  input  logic                  reset,
  io_uart_tx_responder_if.slave bus,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          overflow;
  logic [15:0]   div;
  logic [15:0]   bitdiv;
  logic [15:0]   clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;

  logic          sel;
  logic [1:0]    idx;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          expire;
  logic          stop_to_idle;
  logic [4:0]    count_ext;
  logic [3:0]    count_disp;

  assign sel      = (bus.io_addr[WIDTH-1:2] == BASE[WIDTH-1:2]);
  assign idx      = bus.io_addr[1:0];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus.io_write && sel && (idx == 2'd0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    expire       = (clk_cnt == bitdiv - 16'd1);
    pop          = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      STOP:    pop = expire && !empty;
      default: pop = 1'b0;
    endcase
    stop_to_idle = (state == STOP) && expire && empty;
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + CW'(1);
    else if (!push_ok && pop)
      count_nxt = count - CW'(1);
  end

  // Status shows 4 bits of count; a full 16-deep FIFO displays 15.
  assign count_ext  = 5'(count);
  assign count_disp = count_ext[4] ? 4'hF : count_ext[3:0];

  // Reads have no strobe and no side effects.
  always_comb begin
    bus.io_rd_data = '0;
    if (sel) begin
      case (idx)
        2'd1: begin
          bus.io_rd_data[0]   = full;
          bus.io_rd_data[1]   = empty && (state == IDLE);
          bus.io_rd_data[2]   = overflow;
          bus.io_rd_data[7:4] = count_disp;
        end
        2'd2:    bus.io_rd_data[15:0] = div;
        default: bus.io_rd_data = '0;
      endcase
    end
  end

  // FIFO storage carries no reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= bus.io_wr_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DIV_RESET[15:0];
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (bus.io_write && sel && (idx == 2'd1) && bus.io_wr_data[2])
        overflow <= 1'b0;
      if (bus.io_write && sel && (idx == 2'd2))
        div <= (bus.io_wr_data[15:0] == 16'd0) ? 16'd1 : bus.io_wr_data[15:0];
    end
  end

  // Serializer. clk_cnt counts clocks spent in the current bit; a bit ends when it
  // reaches bitdiv-1, so every bit lasts exactly bitdiv clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      bitdiv  <= DIV_RESET[15:0];
      shifter <= '0;
    end else begin
      tx_busy <= (count_nxt != '0) || pop || ((state != IDLE) && !stop_to_idle);
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shifter <= mem[rd_ptr];
            bitdiv  <= div;
            clk_cnt <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (expire) begin
            clk_cnt <= '0;
            tx      <= shifter[0];
            shifter <= shifter >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        DATA: begin
          if (expire) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shifter[0];
              shifter <= shifter >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        STOP: begin
          if (expire) begin
            clk_cnt <= '0;
            if (pop) begin
              // Back-to-back frame: no idle gap between stop and start.
              shifter <= mem[rd_ptr];
              bitdiv  <= div;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx_responder.sv
// tb/tb_io_uart_tx_responder.sv - directed bench with frame scoreboard for io_uart_tx_responder
module tb_io_uart_tx_responder;

  localparam logic [15:0] BASE = 16'h4000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic tx_busy;

  io_uart_tx_responder_if #(.WIDTH(16)) bus ();

  io_uart_tx_responder #(
    .WIDTH(16),
    .BASE(16'h4000),
    .DEPTH(8),
    .DIV_RESET(217)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] div;
    logic [7:0]  data;
  } frame_t;

  frame_t sb[$];
  int     rx_start[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     rx_done  = 0;
  bit     rx_en    = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    bus.io_addr    = a;
    bus.io_wr_data = d;
    bus.io_write   = 1'b1;
    @(posedge clock);
    #1;
    bus.io_write   = 1'b0;
    bus.io_wr_data = 16'h0000;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.io_addr = a;
    #1;
    check(tag, 32'(bus.io_rd_data), 32'(exp));
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_done < n && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    check("rx_frames_done", 32'(rx_done), 32'(n));
  endtask

  // Serial receiver: takes each frame's expected divisor and byte from the scoreboard.
  initial begin : rx
    frame_t     e;
    int         d;
    int         pos;
    int         tgt;
    logic [7:0] b;
    logic       unexp;
    forever begin
      @(negedge clock);
      if (rx_en && tx === 1'b0) begin
        unexp = (sb.size() == 0);
        check("rx_frame_expected", {31'b0, unexp}, 32'd0);
        if (unexp) begin
          e.div  = 16'd4;
          e.data = 8'h00;
        end else begin
          e = sb.pop_front();
        end
        d = int'(e.div);
        rx_start.push_back(cyc);
        pos = 0;
        for (int i = 0; i < 8; i++) begin
          tgt = d * (1 + i) + d / 2;
          repeat (tgt - pos) @(negedge clock);
          pos = tgt;
          b[i] = tx;
        end
        tgt = 9 * d + d / 2;
        repeat (tgt - pos) @(negedge clock);
        check("rx_stop_bit", 32'(tx), 32'd1);
        if (!unexp)
          check("rx_data", 32'(b), 32'(e.data));
        rx_done++;
      end
    end
  end

  initial begin : main
    int base;
    bus.io_addr    = 16'h0000;
    bus.io_write   = 1'b0;
    bus.io_wr_data = 16'h0000;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    rx_en = 1'b1;

    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    read_chk("status_reset", BASE + 16'd1, 16'h0002);
    read_chk("unselected_read", 16'h4004, 16'h0000);
    read_chk("txdata_read", BASE, 16'h0000);
    read_chk("reserved_read", BASE + 16'd3, 16'h0000);
    read_chk("div_reset", BASE + 16'd2, 16'd217);
    step(5);
    check("tx_idle_steady", 32'(tx), 32'd1);

    // Single frame 0xA5 at DIV=4, exact latency and length.
    cpu_write(BASE + 16'd2, 16'd4);
    read_chk("div_4", BASE + 16'd2, 16'd4);
    sb.push_back('{16'd4, 8'hA5});
    cpu_write(BASE, 16'hFFA5);
    check("lat_tx_after_E", 32'(tx), 32'd1);
    check("lat_busy_after_E", 32'(tx_busy), 32'd1);
    read_chk("lat_count1", BASE + 16'd1, 16'h0010);
    step(1);
    check("start_tx_low", 32'(tx), 32'd0);
    read_chk("status_popped", BASE + 16'd1, 16'h0000);
    step(39);
    check("stop_tx_high", 32'(tx), 32'd1);
    check("busy_end_frame", 32'(tx_busy), 32'd1);
    step(1);
    check("busy_after_frame", 32'(tx_busy), 32'd0);
    read_chk("status_idle_a5", BASE + 16'd1, 16'h0002);
    wait_rx(1, 100);

    // Three contiguous frames.
    base = rx_done;
    sb.push_back('{16'd4, 8'h01});
    sb.push_back('{16'd4, 8'h02});
    sb.push_back('{16'd4, 8'h03});
    cpu_write(BASE, 16'h0001);
    cpu_write(BASE, 16'h0002);
    cpu_write(BASE, 16'h0003);
    read_chk("count_2", BASE + 16'd1, 16'h0020);
    step(39);
    read_chk("count_1", BASE + 16'd1, 16'h0010);
    step(40);
    read_chk("count_0", BASE + 16'd1, 16'h0000);
    wait_rx(base + 3, 200);
    check("gap_frame_1_2", 32'(rx_start[base + 1] - rx_start[base]), 32'd40);
    check("gap_frame_2_3", 32'(rx_start[base + 2] - rx_start[base + 1]), 32'd40);
    step(3);
    read_chk("status_idle_3", BASE + 16'd1, 16'h0002);

    // Fill to full during a slow frame, then overflow and clear.
    cpu_write(BASE + 16'd2, 16'd1000);
    base = rx_done;
    sb.push_back('{16'd1000, 8'h10});
    cpu_write(BASE, 16'h0010);
    step(2);
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{16'd2, 8'(8'h11 + i)});
      cpu_write(BASE, 16'(16'h0011 + i));
    end
    read_chk("status_full", BASE + 16'd1, 16'h0081);
    cpu_write(BASE, 16'h00EE);
    read_chk("status_overflow", BASE + 16'd1, 16'h0085);
    cpu_write(BASE + 16'd1, 16'h0003);
    read_chk("overflow_kept", BASE + 16'd1, 16'h0085);
    cpu_write(BASE + 16'd1, 16'h0004);
    read_chk("overflow_cleared", BASE + 16'd1, 16'h0081);
    cpu_write(BASE + 16'd2, 16'd2);
    wait_rx(base + 9, 11000);
    step(5);
    read_chk("status_idle_ovf", BASE + 16'd1, 16'h0002);

    // Reset in the middle of a frame.
    cpu_write(BASE + 16'd2, 16'd4);
    base = rx_done;
    rx_en = 1'b0;
    cpu_write(BASE, 16'h005A);
    step(1);
    step(14);
    reset = 1'b1;
    step(1);
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    read_chk("midreset_status", BASE + 16'd1, 16'h0002);
    read_chk("midreset_div", BASE + 16'd2, 16'd217);
    step(2);
    check("midreset_tx_steady", 32'(tx), 32'd1);
    check("midreset_no_frame", 32'(rx_done), 32'(base));
    rx_en = 1'b1;

    // DIV=0 stores 1; frame of 0xFF lasts 10 clocks.
    cpu_write(BASE + 16'd2, 16'd0);
    read_chk("div_zero_is_1", BASE + 16'd2, 16'd1);
    base = rx_done;
    sb.push_back('{16'd1, 8'hFF});
    cpu_write(BASE, 16'h00FF);
    step(1);
    check("div1_start_low", 32'(tx), 32'd0);
    step(1);
    check("div1_bit0_high", 32'(tx), 32'd1);
    step(8);
    check("div1_busy_last", 32'(tx_busy), 32'd1);
    step(1);
    check("div1_busy_done", 32'(tx_busy), 32'd0);
    wait_rx(base + 1, 50);

    step(20);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_uart_tx_responder.md
Name: io_uart_tx_responder

Overview:
- Memory-mapped UART transmitter that sits on the CPU I/O bus as a responder. It decodes `io_addr`, accepts bytes written by the CPU into a TX FIFO, and returns status combinationally on `io_rd_data`.
- It serializes FIFO bytes as 8N1 frames on `tx`, at a clock divisor the CPU can program.
- Several responders share the bus: each one drives zero on `io_rd_data` when not selected, and the top level ORs them together.

Parameters:
- WIDTH, 16, CPU data/address width.
- BASE, 16'h4000, register block base address; must be 4-aligned and have `BASE[15:14]` != 0 (I/O space).
- DEPTH, 8, TX FIFO entries; power of 2, range 2..16.
- DIV_RESET, 217, reset value of the baud divisor in clocks per bit (25 MHz / 115200).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- io_addr  in  WIDTH  CPU I/O address; driven continuously, with no read strobe.
- io_write  in  1  single-cycle write strobe.
- io_wr_data  in  WIDTH  write data.
- io_rd_data  out  WIDTH  combinational read data; 0 when not selected.
- tx  out  1  serial line, idle high; registered.
- tx_busy  out  1  1 when the FIFO is non-empty or a frame is in progress; registered.

Behaviour:
- Select: `sel` = (`io_addr[WIDTH-1:2]` == `BASE[WIDTH-1:2]`). Register index = `io_addr[1:0]`.
- Reads have no strobe, so they must be side-effect free.
- `io_rd_data` is purely combinational from `io_addr` and current state, because the CPU samples it at the same edge.
- Register 0, TXDATA:
  - Write: pushes `io_wr_data[7:0]`; upper bits are ignored.
  - Read: returns 0.
- Register 1, STATUS:
  - Read: bit0 = full; bit1 = idle (FIFO empty and no frame in progress); bit2 = overflow (sticky); bits[7:4] = FIFO count (saturating display, 4 bits); all other bits 0.
  - Write: clears overflow only if `io_wr_data[2]` = 1; other bits are ignored.
- Register 2, DIV:
  - Read/write, 16 bits.
  - A write of 0 stores 1.
  - The value is latched into the bit timer at frame start, so a mid-frame change affects the next frame only.
- Register 3: reserved; reads 0, writes ignored.
- Write to TXDATA when full (count == DEPTH): byte dropped, overflow set, FIFO unchanged.
- Push and pop in the same cycle: both happen and count is unchanged. This is legal even when full, because the pop frees the slot first and the push is accepted without overflow.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty: pop, load the shifter, latch DIV into `bitdiv`, `tx`<=0, go to START.
  - START: hold `tx`=0 for `bitdiv` clocks, then drive bit0 and go to DATA.
  - DATA: each bit is held `bitdiv` clocks, LSB first. After bit7 completes, `tx`<=1 and go to STOP.
  - STOP: hold `tx`=1 for `bitdiv` clocks. At expiry, if the FIFO is non-empty, pop, latch DIV, `tx`<=0 and go to START with no idle gap; otherwise go to IDLE.
- Frame length is exactly 10*`bitdiv` clocks.
- Latency: TXDATA write sampled at edge E with the FIFO empty and the FSM in IDLE gives count=1 after E; `tx` falls after edge E+1.
- `tx_busy`: registered, 1 from the edge after the push until the STOP->IDLE edge.
- Reset (synchronous, applies mid-frame): FIFO pointers and count = 0, overflow = 0, DIV = DIV_RESET, FSM = IDLE, `tx` = 1, `tx_busy` = 0, bit counters = 0. A frame in progress is truncated.
- FIFO pointers wrap modulo DEPTH.
- All arithmetic is unsigned.

Test Plan:
- Reset, then read BASE+1 -> `io_rd_data` = 16'h0002; `tx`=1 steady; read of a non-selected address (16'h4004) -> 0.
- Write DIV=4, then TXDATA=8'hA5 -> `tx` low after edge E+1 for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, stop high for 4 clocks; frame length 40 clocks; `tx_busy` drops after the stop bit.
- DIV=4, write 3 bytes (8'h01, 8'h02, 8'h03) back-to-back -> three contiguous frames of 120 clocks total with no idle gap between stop and start; STATUS count decrements 2,1,0 at each pop.
- DIV=1000, write 9 bytes with DEPTH=8 while the first frame is in flight (1 already popped) -> all accepted, STATUS full=1, count=8. A 10th write -> overflow=1 and the byte is not transmitted. Writing STATUS with 16'h0004 -> overflow=0.
- DIV=4, assert reset at clock 15 of a frame -> `tx`=1 and `tx_busy`=0 after that edge, STATUS=16'h0002, DIV reads back 217.
- Write DIV=0 -> DIV reads 1, then a frame of 8'hFF -> 10 clocks total.
